trace_recorder: RTL and testbench

Captures one retirement record per clock from the single-cycle RISC-V core's observable datapath signals (pc, instr, write_back, onzc, reg_write, memory_write). Records are buffered in a small FIFO and streamed out as four RegBits-wide words over a valid/ready interface. The recorder sits beside the core and consumes the same signals the DUT exports, so trace dumping or on-chip checking runs without a clocking-block bench. Overflow is detected, counted, and flagged in the stream.

---
 rtl/trace_recorder_if.sv | 16 +
 rtl/trace_recorder.sv | 125 ++++++++++++
 tb/tb_trace_recorder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_recorder_if.sv
// Stream port of the trace recorder: one RegBits-wide word per valid/ready handshake.
//   out_valid  word available (master -> slave)
//   out_ready  consumer accepts word (slave -> master)
//   out_data   stream word
//   out_last   last word of a record
interface trace_recorder_if #(
   parameter int unsigned RegBits = 32
);
   logic               out_valid;
   logic               out_ready;
   logic [RegBits-1:0] out_data;
   logic               out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/trace_recorder.sv
// Retirement trace recorder: captures one record per enabled clock from the core's
// datapath, buffers records in a Depth-entry FIFO and streams each record as four words.
//   clk, rst          clock, asynchronous active-low reset
//   capture_en        record this cycle's retirement
//   pc/instr/write_back/onzc/reg_write/memory_write   retirement fields
//   out_if            stream port (out_valid/out_ready/out_data/out_last)
//   fifo_count        records held
//   drop_count        records lost to overflow, saturating
module trace_recorder #(
   parameter int unsigned RegBits = 32,
   parameter int unsigned Depth   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     capture_en,
   input  logic [RegBits-1:0]       pc,
   input  logic [RegBits-1:0]       instr,
   input  logic [RegBits-1:0]       write_back,
   input  logic [3:0]               onzc,
   input  logic                     reg_write,
   input  logic                     memory_write,
   trace_recorder_if.master         out_if,
   output logic [$clog2(Depth):0]   fifo_count,
   output logic [15:0]              drop_count
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned SeqW = RegBits - 8;

   typedef enum logic [1:0] {W0, W1, W2, W3} word_idx_t;
   typedef logic [3:0][RegBits-1:0] rec_t;

   word_idx_t           word_idx, word_idx_nxt;
   rec_t                mem [Depth];
   logic [PtrW-1:0]     rd_ptr, wr_ptr, rd_ptr_nxt;
   logic [SeqW-1:0]     seq;
   logic                drop_pending;
   logic                out_valid_q, out_last_q;
   logic [RegBits-1:0]  out_data_q, data_nxt;
   logic [CntW-1:0]     cnt_nxt;
   logic                full, hs, pop, push, drop;
   rec_t                new_rec, head_nxt;

   assign out_if.out_valid = out_valid_q;
   assign out_if.out_last  = out_last_q;
   assign out_if.out_data  = out_data_q;

   // Serializer state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) word_idx <= W0;
      else      word_idx <= word_idx_nxt;
   end

   // Next word index, push/pop/drop decisions and next head word
   always_comb begin
      word_idx_nxt = word_idx;
      pop          = 1'b0;
      full         = (fifo_count == CntW'(Depth));
      hs           = out_valid_q & out_if.out_ready;
      if (hs) begin
         case (word_idx)
            W0: word_idx_nxt = W1;
            W1: word_idx_nxt = W2;
            W2: word_idx_nxt = W3;
            W3: begin
               word_idx_nxt = W0;
               pop          = 1'b1;
            end
            default: word_idx_nxt = W0;
         endcase
      end
      // a same-edge pop frees the slot the incoming record needs
      push = capture_en & (~full | pop);
      drop = capture_en & full & ~pop;

      new_rec    = '0;
      new_rec[0] = pc;
      new_rec[1] = instr;
      new_rec[2] = write_back;
      new_rec[3] = {seq, onzc, reg_write, memory_write, drop_pending, 1'b1};

      cnt_nxt    = fifo_count + CntW'(push) - CntW'(pop);
      rd_ptr_nxt = pop ? rd_ptr + PtrW'(1) : rd_ptr;
      // the new head is the incoming record when it lands where the read pointer will be
      head_nxt   = (push && (rd_ptr_nxt == wr_ptr)) ? new_rec : mem[rd_ptr_nxt];
      data_nxt   = (cnt_nxt != '0) ? head_nxt[word_idx_nxt] : '0;
   end

   // Record storage (no reset; validity tracked by fifo_count)
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= new_rec;
   end

   // Pointers, counters, drop tracking and registered stream outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         fifo_count   <= '0;
         drop_count   <= '0;
         seq          <= '0;
         drop_pending <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
      end else begin
         rd_ptr     <= rd_ptr_nxt;
         fifo_count <= cnt_nxt;
         if (push) begin
            wr_ptr       <= wr_ptr + PtrW'(1);
            drop_pending <= 1'b0;
         end
         if (drop) begin
            drop_pending <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
         if (capture_en) seq <= seq + SeqW'(1);
         out_valid_q <= (cnt_nxt != '0);
         out_last_q  <= (cnt_nxt != '0) && (word_idx_nxt == W3);
         out_data_q  <= data_nxt;
      end
   end

endmodule

// File: tb/tb_trace_recorder.sv
module tb_trace_recorder;

   logic        clk;
   logic        rst_n, rst16;
   logic        cap, cap16, ready, rdy16;
   logic [31:0] pc, instr, wb;
   logic [3:0]  onzc;
   logic        rw, mw;
   logic [3:0]  fifo_count, fifo_count16;
   logic [15:0] drop_count, drop_count16;
   logic [15:0] z16;
   logic        chk_en;

   int n_chk  = 0;
   int n_fail = 0;

   trace_recorder_if #(.RegBits(32)) sif ();
   trace_recorder_if #(.RegBits(16)) sif16 ();

   assign sif.out_ready   = ready;
   assign sif16.out_ready = rdy16;

   trace_recorder #(.RegBits(32), .Depth(8)) dut (
      .clk(clk), .rst(rst_n), .capture_en(cap), .pc(pc), .instr(instr),
      .write_back(wb), .onzc(onzc), .reg_write(rw), .memory_write(mw),
      .out_if(sif), .fifo_count(fifo_count), .drop_count(drop_count)
   );

   trace_recorder #(.RegBits(16), .Depth(8)) dut16 (
      .clk(clk), .rst(rst16), .capture_en(cap16), .pc(z16), .instr(z16),
      .write_back(z16), .onzc(4'h0), .reg_write(1'b0), .memory_write(1'b0),
      .out_if(sif16), .fifo_count(fifo_count16), .drop_count(drop_count16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of whole records plus the index of the word on offer
   logic [3:0][31:0] mq[$];
   logic [3:0][31:0] mrec;
   int               widx;
   logic [23:0]      mseq;
   logic             mpend;
   logic [15:0]      mdrop;
   bit               m_full, m_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         widx  = 0;
         mseq  = '0;
         mpend = 1'b0;
         mdrop = '0;
      end else begin
         m_full = (mq.size() == 8);
         m_pop  = 1'b0;
         if (mq.size() != 0 && ready) begin
            if (widx == 3) begin
               m_pop = 1'b1;
               widx  = 0;
               void'(mq.pop_front());
            end else begin
               widx++;
            end
         end
         if (cap) begin
            if (!m_full || m_pop) begin
               mrec[0] = pc;
               mrec[1] = instr;
               mrec[2] = wb;
               mrec[3] = {mseq, onzc, rw, mw, mpend, 1'b1};
               mq.push_back(mrec);
               mpend = 1'b0;
            end else begin
               if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
               mpend = 1'b1;
            end
            mseq = mseq + 24'd1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("out_valid", 32'(sif.out_valid), 32'(mq.size() != 0));
         chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
         chk("drop_count", 32'(drop_count), 32'(mdrop));
         chk("out_last", 32'(sif.out_last), 32'(mq.size() != 0 && widx == 3));
         if (mq.size() != 0) chk("out_data", sif.out_data, mq[0][widx]);
      end
   end

   // Accepted-word monitors
   logic [31:0] got[$];
   logic        gotlast[$];
   logic [15:0] got16[$];

   always @(posedge clk) begin
      if (rst_n && sif.out_valid && ready) begin
         got.push_back(sif.out_data);
         gotlast.push_back(sif.out_last);
      end
      if (rst16 && sif16.out_valid && rdy16) got16.push_back(sif16.out_data);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic capture(input logic [31:0] p, input logic [31:0] i, input logic [31:0] w,
                          input logic [3:0] f, input logic r, input logic m);
      pc = p; instr = i; wb = w; onzc = f; rw = r; mw = m;
      cap = 1'b1;
      tick();
      cap = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      ready = 1'b1;
      while (sif.out_valid === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(sif.out_valid), 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   logic [3:0] lastpat;

   initial begin
      rst_n = 1'b0; rst16 = 1'b0; cap = 1'b0; cap16 = 1'b0; ready = 1'b0; rdy16 = 1'b0;
      pc = '0; instr = '0; wb = '0; onzc = '0; rw = 1'b0; mw = 1'b0; z16 = '0; chk_en = 1'b0;
      repeat (3) tick();

      // reset state
      chk("rst_out_valid", 32'(sif.out_valid), 32'h0);
      chk("rst_out_last", 32'(sif.out_last), 32'h0);
      chk("rst_out_data", sif.out_data, 32'h0);
      chk("rst_fifo_count", 32'(fifo_count), 32'h0);
      chk("rst_drop_count", 32'(drop_count), 32'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // single record
      ready = 1'b1;
      got.delete(); gotlast.delete();
      capture(32'h0000_0010, 32'h0050_0093, 32'h5, 4'h0, 1'b1, 1'b0);
      wait_drain();
      chk("single_n", 32'(got.size()), 32'd4);
      chk("single_w0", got[0], 32'h0000_0010);
      chk("single_w1", got[1], 32'h0050_0093);
      chk("single_w2", got[2], 32'h0000_0005);
      chk("single_w3", got[3], 32'h0000_0009);
      lastpat = {gotlast[3], gotlast[2], gotlast[1], gotlast[0]};
      chk("single_last", 32'(lastpat), 32'h8);
      chk("single_count", 32'(fifo_count), 32'h0);

      // backpressure at W2
      got.delete();
      capture(32'hA0, 32'h11, 32'h22, 4'hA, 1'b0, 1'b1);
      tick(); tick();
      ready = 1'b0;
      repeat (10) tick();
      chk("bp_hold_data", sif.out_data, 32'h22);
      chk("bp_hold_valid", 32'(sif.out_valid), 32'h1);
      wait_drain();
      chk("bp_n", 32'(got.size()), 32'd4);
      chk("bp_w2", got[2], 32'h22);
      chk("bp_w3", got[3], 32'h0000_01A5);

      // overflow
      do_reset();
      ready = 1'b0;
      pc = 32'h0; instr = 32'h0; wb = 32'h0; onzc = 4'h0; rw = 1'b0; mw = 1'b0;
      cap = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pc = 32'(i);
         tick();
      end
      cap = 1'b0;
      chk("ovf_count", 32'(fifo_count), 32'd8);
      chk("ovf_drops", 32'(drop_count), 32'd2);
      wait_drain();
      got.delete();
      ready = 1'b0;
      capture(32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      capture(32'h200, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      wait_drain();
      chk("ovf_dropped_bit", 32'(got[3][1]), 32'h1);
      chk("ovf_seq", 32'(got[3][31:8]), 32'd10);
      chk("ovf_next_bit", 32'(got[7][1]), 32'h0);
      chk("ovf_next_seq", 32'(got[7][31:8]), 32'd11);

      // full with same-edge pop
      do_reset();
      ready = 1'b0;
      cap = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pc = 32'(i);
         tick();
      end
      cap = 1'b0;
      chk("full_count", 32'(fifo_count), 32'd8);
      ready = 1'b1;
      tick(); tick(); tick();
      pc = 32'h77;
      cap = 1'b1;
      tick();
      cap = 1'b0;
      ready = 1'b0;
      chk("samepop_count", 32'(fifo_count), 32'd8);
      chk("samepop_drops", 32'(drop_count), 32'd0);
      chk("samepop_head", sif.out_data, 32'h1);
      wait_drain();

      // reset mid-operation at W1 with 5 records queued
      ready = 1'b0;
      cap = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pc = 32'(i + 16);
         tick();
      end
      cap = 1'b0;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk("midrst_at_w1", sif.out_data, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(sif.out_valid), 32'h0);
      chk("midrst_count", 32'(fifo_count), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      got.delete();
      ready = 1'b1;
      capture(32'h300, 32'h1, 32'h2, 4'h0, 1'b0, 1'b0);
      wait_drain();
      chk("midrst_seq", 32'(got[3][31:8]), 32'h0);
      chk("midrst_w0", got[0], 32'h300);

      // drop_count saturation
      ready = 1'b0;
      cap = 1'b1;
      repeat (70010) tick();
      cap = 1'b0;
      chk("sat_drops", 32'(drop_count), 32'h0000_FFFF);
      chk("sat_count", 32'(fifo_count), 32'd8);
      wait_drain();

      // seq wrap on the 16-bit instance
      chk_en = 1'b0;
      rst16 = 1'b1;
      tick();
      rdy16 = 1'b0;
      cap16 = 1'b1;
      repeat (255) tick();
      cap16 = 1'b0;
      chk("w16_drops", 32'(drop_count16), 32'd247);
      rdy16 = 1'b1;
      repeat (40) tick();
      chk("w16_empty", 32'(fifo_count16), 32'd0);
      got16.delete();
      cap16 = 1'b1;
      tick();
      cap16 = 1'b0;
      repeat (10) tick();
      cap16 = 1'b1;
      tick();
      cap16 = 1'b0;
      repeat (10) tick();
      chk("w16_n", 32'(got16.size()), 32'd8);
      chk("w16_seq255", 32'(got16[3]), 32'h0000_FF03);
      chk("w16_seq0", 32'(got16[7]), 32'h0000_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
